// File: rtl/uart_rx_if.sv
// Byte-side handshake between uart_rx and its consumer.
// master drives the byte and status; slave returns the ack.
`timescale 1ns/1ps
interface uart_rx_if;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ack;
    logic       frame_err;
    logic       overrun;

    modport master (
        output dout,
        output dout_valid,
        output frame_err,
        output overrun,
        input  dout_ack
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  overrun,
        output dout_ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Received bytes are held in dout with a valid/ack handshake.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_in,
    uart_rx_if.master bus
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_nx;

    logic          rx_m, rx_s;
    logic [PW-1:0] pre;
    logic [3:0]    tcnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          v7, v8;
    logic          tick, decide, bit_end;
    logic          vote, start_det;
    logic          load, ferr;

    assign tick      = (pre == PRE_MAX);
    assign decide    = tick && (tcnt == 4'd9);
    assign bit_end   = tick && (tcnt == 4'd15);
    assign vote      = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
    assign start_det = (state == IDLE) && !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    // Prescaler and tick counter realign to the detected start edge
    always_ff @(posedge clk) begin
        if (rst || start_det) begin
            pre  <= '0;
            tcnt <= '0;
        end else if (tick) begin
            pre  <= '0;
            tcnt <= tcnt + 4'd1;
        end else begin
            pre  <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v7 <= 1'b0;
            v8 <= 1'b0;
        end else if (tick) begin
            if (tcnt == 4'd7) v7 <= rx_s;
            if (tcnt == 4'd8) v8 <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        ferr     = 1'b0;
        unique case (state)
            WAIT_IDLE: if (rx_s) state_nx = IDLE;
            IDLE:      if (!rx_s) state_nx = START;
            START: begin
                if (decide && vote) state_nx = IDLE;
                else if (bit_end)   state_nx = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) state_nx = STOP;
            end
            STOP: begin
                if (decide) begin
                    load     = vote;
                    ferr     = !vote;
                    state_nx = vote ? IDLE : WAIT_IDLE;
                end
            end
            default: state_nx = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            shift   <= '0;
        end else if (state == START && bit_end) begin
            bit_idx <= '0;
        end else if (state == DATA) begin
            if (decide)  shift[bit_idx] <= vote;
            if (bit_end) bit_idx <= bit_idx + 3'd1;
        end
    end

    // A completing byte always wins over an ack landing the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_err <= ferr;
            if (bus.dout_valid && bus.dout_ack) begin
                bus.dout_valid <= 1'b0;
                bus.overrun    <= 1'b0;
            end
            if (load) begin
                bus.dout       <= shift;
                bus.dout_valid <= 1'b1;
                if (bus.dout_valid && !bus.dout_ack) bus.overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV = 1 (16 clocks per bit).
// Expected bytes are queued at stimulus time; a monitor pops on each new byte.
`timescale 1ns/1ps
module tb_uart_rx;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rx_in = 1'b1;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ(1600000),
        .BAUD    (100000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_in(rx_in),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       ovr;
        logic       lat;
    } exp_t;

    exp_t sb[$];

    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   n_evt    = 0;
    int   fe_cnt   = 0;
    logic auto_ack  = 1'b0;
    logic force_ack = 1'b0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.dout_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.dout_ack = force_ack ||
                (auto_ack && bus.dout_valid && !bus.dout_ack);
        end
    end

    // New byte: valid rises, or dout changes while valid stays high
    initial begin
        logic       pv;
        logic [7:0] pd;
        exp_t       e;
        int         lat;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (bus.dout_valid && (!pv || bus.dout != pd)) begin
                n_evt = n_evt + 1;
                if (sb.size() == 0) begin
                    n_chk  = n_chk + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_byte: got %0h, expected none",
                             bus.dout);
                end else begin
                    e = sb.pop_front();
                    chk("dout", bus.dout, e.data);
                    chk("overrun", bus.overrun, e.ovr);
                    chk("frame_err_on_byte", bus.frame_err, 0);
                    if (e.lat) begin
                        lat   = cyc - fall_cyc;
                        n_chk = n_chk + 1;
                        if (lat < 154 || lat > 158) begin
                            n_fail = n_fail + 1;
                            $display("FAIL latency: got %0d, expected 154..158",
                                     lat);
                        end
                    end
                end
            end
            if (bus.frame_err) fe_cnt = fe_cnt + 1;
            pv = bus.dout_valid;
            pd = bus.dout;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic ovr,
                        input logic lat);
        exp_t e;
        e.data = d;
        e.ovr  = ovr;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // One frame, 16 clocks per bit; optional single-clock inverted glitch
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int gbit, input int goff);
        logic [9:0] fr;
        fr       = {stop, d, 1'b0};
        fall_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 16; j++) begin
                rx_in = fr[b] ^ ((b == gbit) && (j == goff));
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic do_ack(input string name);
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk({name, "_valid_clr"}, bus.dout_valid, 0);
        chk({name, "_ovr_clr"}, bus.overrun, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() > 0; i++) idle(1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        int ev0;
        int fe0;

        idle(3);
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_ovr", bus.overrun, 0);
        rst = 1'b0;
        idle(20);

        push(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b1, -1, 0);
        chk("a5_valid", bus.dout_valid, 1);
        do_ack("a5");
        idle(10);

        auto_ack = 1'b1;
        fe0 = fe_cnt;
        ev0 = n_evt;
        push(8'h00, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b1, -1, 0);
        send_frame(8'h55, 1'b1, -1, 0);
        idle(20);
        drain();
        auto_ack = 1'b0;
        chk("b2b_count", n_evt - ev0, 3);
        chk("b2b_no_ferr", fe_cnt - fe0, 0);
        chk("b2b_valid_clr", bus.dout_valid, 0);

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, 0);
        idle(20);
        chk("ferr_pulse_len", fe_cnt - fe0, 1);
        chk("ferr_valid", bus.dout_valid, 0);
        chk("ferr_dout_kept", bus.dout, 8'h55);
        push(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, -1, 0);
        idle(5);
        do_ack("x81");

        ev0 = n_evt;
        fe0 = fe_cnt;
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(100);
        chk("low_glitch_bytes", n_evt - ev0, 0);
        chk("low_glitch_ferr", fe_cnt - fe0, 0);

        push(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 4, 9);
        idle(5);
        do_ack("vote");

        push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, -1, 0);
        push(8'h22, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, -1, 0);
        idle(5);
        chk("ovr_set", bus.overrun, 1);
        chk("ovr_valid", bus.dout_valid, 1);
        do_ack("ovr");

        push(8'h33, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, -1, 0);
        push(8'h44, 1'b0, 1'b0);
        fork
            send_frame(8'h44, 1'b1, -1, 0);
            begin
                idle(155);
                force_ack = 1'b1;
                idle(1);
                force_ack = 1'b0;
            end
        join
        idle(5);
        chk("same_cycle_ovr", bus.overrun, 0);
        chk("same_cycle_valid", bus.dout_valid, 1);
        do_ack("x44");

        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, -1, 0);
        idle(5);
        ev0 = n_evt;
        fork
            send_frame(8'hC3, 1'b1, -1, 0);
            begin
                idle(60);
                rst = 1'b1;
                idle(1);
                chk("midrst_dout", bus.dout, 0);
                chk("midrst_valid", bus.dout_valid, 0);
                chk("midrst_ferr", bus.frame_err, 0);
                chk("midrst_ovr", bus.overrun, 0);
                rst = 1'b0;
            end
        join
        idle(20);
        chk("midrst_no_byte", n_evt - ev0, 0);

        fe0 = fe_cnt;
        rx_in = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(400);
        chk("held_low_bytes", n_evt - ev0, 0);
        chk("held_low_ferr", fe_cnt - fe0, 0);
        chk("held_low_valid", bus.dout_valid, 0);
        rx_in = 1'b1;
        idle(20);
        push(8'h7E, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b1, -1, 0);
        idle(5);
        drain();
        chk("final_dout", bus.dout, 8'h7E);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Counterpart of the existing UART transmit path. Lets the host PC send bytes into the FPGA, e.g. command bytes for display mode and unit select.
- Sits between the board RX pin and a byte consumer.
- Delivers each received byte in a holding register with a valid/ack handshake, plus framing-error and overrun status.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. Oversample divider DIV = CLK_FREQ/(BAUD*16), integer division; DIV >= 1 is required (651 at defaults).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idle = 1.
- dout  output  8  last received byte.
- dout_valid  output  1  dout holds an unconsumed byte.
- dout_ack  input  1  consumer takes dout; sampled only while dout_valid = 1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte completed while the previous one was still unconsumed.

Behaviour:
- Reset: dout = 0, dout_valid = 0, frame_err = 0, overrun = 0; synchronizer flops = 0; FSM = WAIT_IDLE; prescaler and counters = 0. Reset mid-frame discards the partial byte.
- Synchronizer: two flops on rx_in, giving rx_s. All logic uses rx_s only.
- Prescaler: counts 0..DIV-1 and emits a one-cycle tick at DIV-1. Forced to 0 on start-edge detection.
- Tick counter: 4 bits, counts 0..15 per bit period and wraps from 15 to 0.
- Bit decision: majority vote of rx_s at ticks 7, 8 and 9 of each bit. Decided on the tick-9 clock.
- FSM states:
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This blocks a false start after reset or a break.
  - IDLE: rx_s = 0 means start edge; go to START and clear the prescaler and tick counter.
  - START: at the tick-9 decision, vote 1 means glitch; return to IDLE with no output and no flags. Vote 0 means wait for tick 15, then go to DATA with bit index = 0.
  - DATA: at each tick-9 decision, shift the voted bit into shift[bit index] (LSB first). At tick 15, increment the index; after index 7 go to STOP.
  - STOP, at the tick-9 decision:
    - Vote 1: load dout = shift, set dout_valid, go to IDLE immediately. Next start may be detected from the following cycle; no wait for end of stop bit.
    - Vote 0: pulse frame_err for exactly one cycle, discard the byte, leave dout and dout_valid unchanged, go to WAIT_IDLE.
- Handshake:
  - dout_valid clears on the cycle after dout_ack = 1 while dout_valid = 1.
  - dout is stable while dout_valid = 1, except on overrun.
- Byte completes while dout_valid = 1 and no ack that cycle: dout is overwritten, dout_valid stays 1, overrun is set.
- Byte completes on the same cycle as an ack: dout gets the new byte, dout_valid stays 1, overrun is not set.
- overrun clears only on an accepted dout_ack or rst.
- dout_ack while dout_valid = 0 is ignored.
- Latency with DIV = 1: dout_valid rises 154..158 clocks after rx_in falls (2-cycle sync + edge + 9 bit periods + 9-10 ticks). The bench checks this window.
- Throughput: back-to-back frames with zero idle between stop and next start are received without loss.

Test Plan:
- DIV = 1 (CLK_FREQ = 1600000, BAUD = 100000), send 0xA5 with 16-clock bits -> dout = 0xA5, dout_valid rises within clocks 154..158, frame_err = 0, overrun = 0; ack -> dout_valid = 0 next cycle.
- Back-to-back 0x00, 0xFF, 0x55 with ack one cycle after each valid -> three valid strobes carrying 0x00, 0xFF, 0x55 in order, no flags.
- Send 0x3C with stop bit forced low, then idle -> frame_err high exactly 1 cycle, dout_valid stays 0, FSM waits for line high; next byte 0x81 is received correctly.
- 4-clock low glitch on idle line -> no dout_valid, no frame_err. 1-clock high glitch at tick 8 of bit 3 of 0x00 -> majority vote still gives dout = 0x00.
- Send 0x11 without ack, then 0x22 -> dout = 0x22, dout_valid = 1, overrun = 1. Ack -> overrun = 0, dout_valid = 0. Repeat with the ack landing on the completion cycle -> overrun stays 0.
- rst asserted mid-DATA of 0xC3 -> all outputs 0 next cycle. rx_in held low after reset -> no reception. Line released high, then 0x7E sent -> dout = 0x7E.
